// File: rtl/core_pkg.sv
// Shared core types: MEM->WB payload layout and skid-buffer occupancy states.
package core_pkg;

    localparam int XLEN        = 32;
    localparam int REG_IDX_W   = 5;
    localparam int RES_SRC_W   = 2;

    // One instruction's worth of writeback information leaving MEM.
    typedef struct packed {
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      pc_plus4;
        logic [XLEN-1:0]      read_data;
        logic [REG_IDX_W-1:0] rd;
        logic [RES_SRC_W-1:0] result_src;
        logic                 reg_write;
    } mem_wb_payload_t;

    // EMPTY: nothing held, ONE: main only, TWO: main and skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with valid/ready handshake and synchronous flush.
// Upstream ready and downstream valid come straight from flops, so no
// combinational path runs from ready_i back to ready_o.
module skid_buffer
    import core_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    skid_state_e      r_state;
    logic             r_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = valid_i & r_ready;
    assign w_out_fire = r_valid & ready_i;

    // Occupancy FSM: moves entries main<-input/skid and keeps valid/ready registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush_i) begin
            // Payload is left stale; only occupancy is cleared.
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= data_i;
                        r_state <= ONE;
                        r_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= data_i;
                    end else if (w_in_fire) begin
                        r_skid  <= data_i;
                        r_state <= TWO;
                        r_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= ONE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign data_o  = r_main;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB stage register with back-pressure, flush and bubble-safe write gating.
// The payload layout comes from core_pkg, so the width parameters are expected
// to stay at the core's widths defined there.
module mem_wb_skid_reg
    import core_pkg::*;
#(
    parameter int DATA_WIDTH       = XLEN,
    parameter int REGISTER_WIDTH   = REG_IDX_W,
    parameter int RESULT_SRC_WIDTH = RES_SRC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        valid_m_i,
    output logic                        ready_m_o,
    input  logic [DATA_WIDTH-1:0]       alu_result_m_i,
    input  logic [DATA_WIDTH-1:0]       pc_plus4_m_i,
    input  logic [DATA_WIDTH-1:0]       read_data_m_i,
    input  logic [REGISTER_WIDTH-1:0]   rd_m_i,
    input  logic [RESULT_SRC_WIDTH-1:0] result_src_m_i,
    input  logic                        reg_write_m_i,
    output logic                        valid_w_o,
    input  logic                        ready_w_i,
    output logic [DATA_WIDTH-1:0]       alu_result_w_o,
    output logic [DATA_WIDTH-1:0]       pc_plus4_w_o,
    output logic [DATA_WIDTH-1:0]       read_data_w_o,
    output logic [REGISTER_WIDTH-1:0]   rd_w_o,
    output logic [RESULT_SRC_WIDTH-1:0] result_src_w_o,
    output logic                        reg_write_w_o
);

    localparam int PAYLOAD_W = $bits(mem_wb_payload_t);

    mem_wb_payload_t w_in;
    mem_wb_payload_t w_out;
    logic [PAYLOAD_W-1:0] w_out_bits;

    // Pack MEM-side fields into the shared payload struct.
    always_comb begin
        w_in            = '0;
        w_in.alu_result = alu_result_m_i;
        w_in.pc_plus4   = pc_plus4_m_i;
        w_in.read_data  = read_data_m_i;
        w_in.rd         = rd_m_i;
        w_in.result_src = result_src_m_i;
        w_in.reg_write  = reg_write_m_i;
    end

    skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .valid_i (valid_m_i),
        .ready_o (ready_m_o),
        .data_i  (w_in),
        .valid_o (valid_w_o),
        .ready_i (ready_w_i),
        .data_o  (w_out_bits)
    );

    assign w_out          = mem_wb_payload_t'(w_out_bits);
    assign alu_result_w_o = w_out.alu_result;
    assign pc_plus4_w_o   = w_out.pc_plus4;
    assign read_data_w_o  = w_out.read_data;
    assign rd_w_o         = w_out.rd;
    assign result_src_w_o = w_out.result_src;
    // A bubble must never write the register file, whatever payload is stale in main.
    assign reg_write_w_o  = w_out.reg_write & valid_w_o;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: reset, streaming, back-pressure,
// flush in TWO, bubble gating and reset mid-stall.
module tb_mem_wb_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        valid_m_i;
    logic        ready_m_o;
    logic [31:0] alu_result_m_i;
    logic [31:0] pc_plus4_m_i;
    logic [31:0] read_data_m_i;
    logic [4:0]  rd_m_i;
    logic [1:0]  result_src_m_i;
    logic        reg_write_m_i;
    logic        valid_w_o;
    logic        ready_w_i;
    logic [31:0] alu_result_w_o;
    logic [31:0] pc_plus4_w_o;
    logic [31:0] read_data_w_o;
    logic [4:0]  rd_w_o;
    logic [1:0]  result_src_w_o;
    logic        reg_write_w_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_wb_skid_reg dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .valid_m_i      (valid_m_i),
        .ready_m_o      (ready_m_o),
        .alu_result_m_i (alu_result_m_i),
        .pc_plus4_m_i   (pc_plus4_m_i),
        .read_data_m_i  (read_data_m_i),
        .rd_m_i         (rd_m_i),
        .result_src_m_i (result_src_m_i),
        .reg_write_m_i  (reg_write_m_i),
        .valid_w_o      (valid_w_o),
        .ready_w_i      (ready_w_i),
        .alu_result_w_o (alu_result_w_o),
        .pc_plus4_w_o   (pc_plus4_w_o),
        .read_data_w_o  (read_data_w_o),
        .rd_w_o         (rd_w_o),
        .result_src_w_o (result_src_w_o),
        .reg_write_w_o  (reg_write_w_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        valid_m_i      = v;
        alu_result_m_i = alu;
        pc_plus4_m_i   = alu + 32'd4;
        read_data_m_i  = ~alu;
        rd_m_i         = rd;
        result_src_m_i = 2'd1;
        reg_write_m_i  = rw;
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; ready_w_i = 1'b1;
        drive(1'b1, 32'hDEAD, 5'd7, 1'b1);

        // Reset held two cycles with a valid beat on the input
        tick(); tick();
        check("rst_valid",  {31'd0, valid_w_o},     32'd0);
        check("rst_rw",     {31'd0, reg_write_w_o}, 32'd0);
        check("rst_alu",    alu_result_w_o,         32'd0);
        check("rst_pc",     pc_plus4_w_o,           32'd0);
        check("rst_rdata",  read_data_w_o,          32'd0);
        check("rst_rd",     {27'd0, rd_w_o},        32'd0);
        check("rst_rsrc",   {30'd0, result_src_w_o},32'd0);
        check("rst_ready",  {31'd0, ready_m_o},     32'd1);
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();

        // Streaming at full rate
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + i, 5'(i + 1), 1'b1);
            check("stream_ready", {31'd0, ready_m_o}, 32'd1);
            tick();
            check("stream_valid", {31'd0, valid_w_o},     32'd1);
            check("stream_alu",   alu_result_w_o,         32'h10 + i);
            check("stream_pc",    pc_plus4_w_o,           32'h14 + i);
            check("stream_rd",    {27'd0, rd_w_o},        32'(i + 1));
            check("stream_rw",    {31'd0, reg_write_w_o}, 32'd1);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        check("stream_drain", {31'd0, valid_w_o}, 32'd0);

        // Back-pressure: A, B stored, C held off until space frees up
        ready_w_i = 1'b0;
        drive(1'b1, 32'hAAAA, 5'd10, 1'b1);
        tick();
        check("bp_A_out",   alu_result_w_o,     32'hAAAA);
        check("bp_ready1",  {31'd0, ready_m_o}, 32'd1);
        drive(1'b1, 32'hBBBB, 5'd11, 1'b1);
        tick();
        check("bp_ready_after_B", {31'd0, ready_m_o}, 32'd0);
        check("bp_A_hold",  alu_result_w_o,     32'hAAAA);
        drive(1'b1, 32'hCCCC, 5'd12, 1'b1);
        tick();
        check("bp_stall_ready", {31'd0, ready_m_o}, 32'd0);
        check("bp_stall_A",     alu_result_w_o,     32'hAAAA);
        ready_w_i = 1'b1;
        tick();
        check("bp_B_out",   alu_result_w_o,     32'hBBBB);
        check("bp_B_rd",    {27'd0, rd_w_o},    32'd11);
        check("bp_ready_rise", {31'd0, ready_m_o}, 32'd1);
        tick();
        check("bp_C_out",   alu_result_w_o,     32'hCCCC);
        check("bp_C_valid", {31'd0, valid_w_o}, 32'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        check("bp_no_dup",  {31'd0, valid_w_o}, 32'd0);

        // Flush while TWO, with D presented the same cycle
        ready_w_i = 1'b0;
        drive(1'b1, 32'h1111, 5'd1, 1'b1); tick();
        drive(1'b1, 32'h2222, 5'd2, 1'b1); tick();
        check("fl_full", {31'd0, ready_m_o}, 32'd0);
        drive(1'b1, 32'hDDDD, 5'd13, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_valid", {31'd0, valid_w_o},     32'd0);
        check("fl_rw",    {31'd0, reg_write_w_o}, 32'd0);
        check("fl_ready", {31'd0, ready_m_o},     32'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        ready_w_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_D",     {31'd0, (valid_w_o && alu_result_w_o == 32'hDDDD)}, 32'd0);
            check("fl_idle",     {31'd0, valid_w_o}, 32'd0);
        end

        // Bubble carrying reg_write=1 must never write
        drive(1'b0, 32'h77, 5'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bubble_rw",    {31'd0, reg_write_w_o}, 32'd0);
            check("bubble_valid", {31'd0, valid_w_o},     32'd0);
        end

        // Reset in the middle of a TWO stall, then a fresh beat E
        ready_w_i = 1'b0;
        drive(1'b1, 32'h3333, 5'd3, 1'b1); tick();
        drive(1'b1, 32'h4444, 5'd4, 1'b1); tick();
        check("rs_full", {31'd0, ready_m_o}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_valid", {31'd0, valid_w_o},     32'd0);
        check("rs_rw",    {31'd0, reg_write_w_o}, 32'd0);
        check("rs_alu",   alu_result_w_o,         32'd0);
        check("rs_rd",    {27'd0, rd_w_o},        32'd0);
        check("rs_ready", {31'd0, ready_m_o},     32'd1);
        ready_w_i = 1'b1;
        drive(1'b1, 32'h55, 5'd9, 1'b1);
        tick();
        check("E_valid", {31'd0, valid_w_o}, 32'd1);
        check("E_alu",   alu_result_w_o,     32'h55);
        check("E_rd",    {27'd0, rd_w_o},    32'd9);
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        check("E_once",  {31'd0, valid_w_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
